sr_drive_ctrl: RTL and testbench



---
 rtl/sr_drive_ctrl_pkg.sv | 23 ++
 rtl/sr_drive_ctrl_if.sv | 33 +++
 rtl/sr_drive_ctrl_req_arb.sv | 52 +++++
 rtl/sr_flipflop.sv | 16 +
 rtl/sr_drive_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sr_drive_ctrl.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/sr_drive_ctrl_pkg.sv
// sr_ctrl_pkg: shared types for the SR drive controller.
//   state_e     - controller phases (IDLE, DRIVE, SETTLE, GAP)
//   cmd_e       - resolved request encoding (none / set / clear / toggle)
//   resolve_cmd - same-cycle request priority: set/clr beat tog, and
//                 prio_set chooses the winner of a set/clr collision.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, GAP} state_e;

    typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR, CMD_TOG} cmd_e;

    function automatic cmd_e resolve_cmd(input logic set, input logic clr,
                                         input logic tog, input logic prio_set);
        cmd_e c;
        c = CMD_NONE;
        if (set && clr)  c = prio_set ? CMD_SET : CMD_CLR;
        else if (set)    c = CMD_SET;
        else if (clr)    c = CMD_CLR;
        else if (tog)    c = CMD_TOG;
        return c;
    endfunction

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// sr_drive_if: command/status bundle between the controlling logic and
// sr_drive_ctrl.
//   master (controller side): drives set_req/clr_req/tog_req/err_clr,
//                             observes busy/target/done/err_*/state_dbg.
//   slave  (sr_drive_ctrl)  : the mirror image.
// Handshake: set_req/clr_req/tog_req are single-cycle strobes with no ready
// back-pressure; a strobe seen while busy is held in a one-deep last-wins
// pending slot, so the controller never has to retry. done, err_conflict
// are one-cycle pulses; err_timeout is sticky until err_clr.
interface sr_drive_if;
    import sr_ctrl_pkg::*;

    logic   set_req;
    logic   clr_req;
    logic   tog_req;
    logic   err_clr;
    logic   busy;
    logic   target;
    logic   done;
    logic   err_conflict;
    logic   err_timeout;
    state_e state_dbg;

    modport master (
        output set_req, clr_req, tog_req, err_clr,
        input  busy, target, done, err_conflict, err_timeout, state_dbg
    );

    modport slave (
        input  set_req, clr_req, tog_req, err_clr,
        output busy, target, done, err_conflict, err_timeout, state_dbg
    );
endinterface

// File: rtl/sr_drive_ctrl_req_arb.sv
// sr_req_arb: request resolution plus the one-entry pending slot.
//   set_req/clr_req/tog_req : raw request strobes
//   take_req   : top launches req_cmd directly this cycle (do not latch it)
//   consume    : top launches the pending entry this cycle
//   req_cmd    : this cycle's resolved request (combinational)
//   pend_valid/pend_cmd : pending entry (registered)
//   err_conflict : registered pulse, set and clear collided last cycle
module sr_req_arb
    import sr_ctrl_pkg::*;
#(
    parameter int PRIO_SET = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic tog_req,
    input  logic take_req,
    input  logic consume,
    output cmd_e req_cmd,
    output logic pend_valid,
    output cmd_e pend_cmd,
    output logic err_conflict
);
    cmd_e pend_q, pend_d;
    logic conf_q, conf_d;

    assign req_cmd = resolve_cmd(set_req, clr_req, tog_req, PRIO_SET != 0);

    // A new request always overwrites the slot, even on the cycle the old
    // entry is consumed, so the newest command is the one that survives.
    always_comb begin
        pend_d = pend_q;
        conf_d = set_req & clr_req;
        if (req_cmd != CMD_NONE && !take_req) pend_d = req_cmd;
        else if (consume)                     pend_d = CMD_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= CMD_NONE;
            conf_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            conf_q <= conf_d;
        end
    end

    assign pend_valid   = (pend_q != CMD_NONE);
    assign pend_cmd     = pend_q;
    assign err_conflict = conf_q;
endmodule

// File: rtl/sr_flipflop.sv
// sr_flipflop: the clocked SR storage element driven by sr_drive_ctrl.
//   clk, rst_n (sync, active-low), s, r in; q out.
// s=r=1 is illegal for the real cell; here it simply holds.
module sr_flipflop (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic r,
    output logic q
);
    always_ff @(posedge clk) begin
        if (!rst_n)         q <= 1'b0;
        else if (s && !r)   q <= 1'b1;
        else if (r && !s)   q <= 1'b0;
    end
endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns set/clear/toggle strobes into PULSE_W-wide s/r
// pulses for an SR flip-flop, confirms the result on q_fb, then enforces
// GAP_W idle cycles before the next command.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : sr_drive_if.slave (requests in, status out)
//   q_fb       : flip-flop output fed back for confirmation
//   s, r       : registered drives, never high together
module sr_drive_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int PULSE_W    = 2,
    parameter int SETTLE_MAX = 8,
    parameter int GAP_W      = 2,
    parameter int PRIO_SET   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    sr_drive_if.slave  bus,
    input  logic       q_fb,
    output logic       s,
    output logic       r
);
    localparam int MAX_PS = (PULSE_W > SETTLE_MAX) ? PULSE_W : SETTLE_MAX;
    localparam int MAXC   = (MAX_PS > GAP_W) ? MAX_PS : GAP_W;
    localparam int CW     = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PW_LAST  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] SM_LAST  = CW'(SETTLE_MAX - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_W > 0) ? GAP_W - 1 : 0);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAXC);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            s_q, s_d, r_q, r_d;
    logic            target_q, target_d;
    logic            done_q, done_d;
    logic            to_q, to_d;
    logic            busy_q, busy_d;

    logic            take_req, consume, launch;
    cmd_e            launch_cmd, req_cmd, pend_cmd;
    logic            pend_valid, err_conflict;

    sr_req_arb #(.PRIO_SET(PRIO_SET)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_req      (bus.set_req),
        .clr_req      (bus.clr_req),
        .tog_req      (bus.tog_req),
        .take_req     (take_req),
        .consume      (consume),
        .req_cmd      (req_cmd),
        .pend_valid   (pend_valid),
        .pend_cmd     (pend_cmd),
        .err_conflict (err_conflict)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
        s_d        = 1'b0;
        r_d        = 1'b0;
        target_d   = target_q;
        done_d     = 1'b0;
        to_d       = bus.err_clr ? 1'b0 : to_q;
        take_req   = 1'b0;
        consume    = 1'b0;
        launch     = 1'b0;
        launch_cmd = CMD_NONE;

        unique case (state_q)
            IDLE: begin
                // A left-over pending entry is older than anything arriving now.
                if (pend_valid) begin
                    launch     = 1'b1;
                    consume    = 1'b1;
                    launch_cmd = pend_cmd;
                end else if (req_cmd != CMD_NONE) begin
                    launch     = 1'b1;
                    take_req   = 1'b1;
                    launch_cmd = req_cmd;
                end
            end
            DRIVE: begin
                if (cnt_q == PW_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    s_d = s_q;
                    r_d = r_q;
                end
            end
            SETTLE: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    state_d = (GAP_W == 0) ? IDLE : GAP;
                    cnt_d   = '0;
                end else if (cnt_q == SM_LAST) begin
                    to_d    = 1'b1;
                    state_d = (GAP_W == 0) ? IDLE : GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (pend_valid) begin
                        launch     = 1'b1;
                        consume    = 1'b1;
                        launch_cmd = pend_cmd;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Toggle target is taken from q_fb at launch, not when it was queued.
        if (launch) begin
            state_d  = DRIVE;
            cnt_d    = '0;
            target_d = (launch_cmd == CMD_TOG) ? ~q_fb : (launch_cmd == CMD_SET);
            s_d      = target_d;
            r_d      = ~target_d;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            target_q <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            r_q      <= r_d;
            target_q <= target_d;
            done_q   <= done_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
        end
    end

    assign s                = s_q;
    assign r                = r_q;
    assign bus.busy         = busy_q;
    assign bus.target       = target_q;
    assign bus.done         = done_q;
    assign bus.err_conflict = err_conflict;
    assign bus.err_timeout  = to_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: two controllers (set-priority and clear-priority) each
// driving an sr_flipflop; the set-priority one is checked every cycle
// against a timeline model, both get directed literal checks.
module tb_sr_drive_ctrl;
    localparam int PW = 2;
    localparam int SM = 8;
    localparam int GW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_low = 1'b0;
    always #5 clk = ~clk;

    sr_drive_if bus0();
    sr_drive_if bus1();
    logic s0, r0, s1, r1, ffq0, ffq1, q_fb0, q_fb1;

    assign q_fb0 = force_low ? 1'b0 : ffq0;
    assign q_fb1 = ffq1;
    assign bus1.set_req = bus0.set_req;
    assign bus1.clr_req = bus0.clr_req;
    assign bus1.tog_req = bus0.tog_req;
    assign bus1.err_clr = bus0.err_clr;

    sr_drive_ctrl #(.PULSE_W(PW), .SETTLE_MAX(SM), .GAP_W(GW), .PRIO_SET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .q_fb(q_fb0), .s(s0), .r(r0));
    sr_flipflop ff0 (.clk(clk), .rst_n(rst_n), .s(s0), .r(r0), .q(ffq0));

    sr_drive_ctrl #(.PULSE_W(PW), .SETTLE_MAX(SM), .GAP_W(GW), .PRIO_SET(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .q_fb(q_fb1), .s(s1), .r(r1));
    sr_flipflop ff1 (.clk(clk), .rst_n(rst_n), .s(s1), .r(r1), .q(ffq1));

    int n_checks = 0;
    int n_fail   = 0;
    int dut_done = 0;

    task automatic chk(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each command is tracked by absolute edge numbers: launch edge m_t0,
    // drive ends at m_t0+PW, q_fb is sampled on edges m_t0+PW+1 ..
    // m_t0+PW+SM, the command concludes at m_end and frees at m_end+GW.
    logic [6:0] exp_q[$];   // {s, r, busy, target, done, conflict, timeout}
    int  edge_n = 0;
    bit  m_valid = 0, m_act = 0, m_tgt = 0, m_ffq = 0, m_s = 0, m_r = 0, m_to = 0;
    int  m_t0 = 0, m_end = -1, m_pend = 0, m_concl = 0, m_toev = 0;

    function automatic int resolve(input bit st, input bit cl, input bit tg);
        if (st && cl) return 1;      // set-priority instance
        if (st) return 1;
        if (cl) return 2;
        if (tg) return 3;
        return 0;
    endfunction

    task automatic model_step();
        bit qfb, done_n, to_evt, launch;
        int req, lcmd;
        edge_n++;
        if (!rst_n) begin
            m_valid = 1; m_act = 0; m_tgt = 0; m_ffq = 0; m_s = 0; m_r = 0;
            m_to = 0; m_pend = 0; m_end = -1;
            exp_q.push_back(7'b0);
            return;
        end
        if (!m_valid) return;
        qfb = force_low ? 1'b0 : m_ffq;
        if (m_s) m_ffq = 1; else if (m_r) m_ffq = 0;
        req = resolve(bus0.set_req, bus0.clr_req, bus0.tog_req);
        done_n = 0; to_evt = 0; launch = 0; lcmd = 0;
        if (m_act) begin
            if (m_end < 0 && edge_n >= m_t0 + PW + 1) begin
                if (qfb == m_tgt) begin
                    m_end = edge_n; done_n = 1; m_concl++;
                end else if (edge_n == m_t0 + PW + SM) begin
                    m_end = edge_n; to_evt = 1; m_concl++; m_toev++;
                end
            end
            if (m_end >= 0 && edge_n == m_end + GW) begin
                if (GW > 0 && m_pend != 0) begin launch = 1; lcmd = m_pend; end
                else m_act = 0;
            end
            if (launch) m_pend = req;
            else if (req != 0) m_pend = req;
        end else begin
            if (m_pend != 0) begin launch = 1; lcmd = m_pend; m_pend = req; end
            else if (req != 0) begin launch = 1; lcmd = req; end
        end
        if (launch) begin
            m_act = 1; m_t0 = edge_n; m_end = -1;
            m_tgt = (lcmd == 3) ? !qfb : (lcmd == 1);
        end
        m_s = m_act && (edge_n < m_t0 + PW) && m_tgt;
        m_r = m_act && (edge_n < m_t0 + PW) && !m_tgt;
        if (to_evt) m_to = 1; else if (bus0.err_clr) m_to = 0;
        exp_q.push_back({m_s, m_r, m_act, m_tgt, done_n,
                         bus0.set_req & bus0.clr_req, m_to});
    endtask

    // ---------------- scoreboard / compare ----------------
    initial begin
        logic [6:0] e;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("s",        s0,                e[6]);
                chk("r",        r0,                e[5]);
                chk("busy",     bus0.busy,         e[4]);
                chk("target",   bus0.target,       e[3]);
                chk("done",     bus0.done,         e[2]);
                chk("conflict", bus0.err_conflict, e[1]);
                chk("timeout",  bus0.err_timeout,  e[0]);
                chk("s_and_r",  s0 & r0,           1'b0);
                if (bus0.done === 1'b1) dut_done++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic req(input logic st, input logic cl, input logic tg, input logic ec);
        @(negedge clk);
        bus0.set_req = st; bus0.clr_req = cl; bus0.tog_req = tg; bus0.err_clr = ec;
    endtask

    task automatic nop(input int k);
        repeat (k) req(0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus0.set_req = 0; bus0.clr_req = 0; bus0.tog_req = 0; bus0.err_clr = 0;
        repeat (3) @(negedge clk);
        chk("rst_s", s0, 1'b0);
        chk("rst_busy", bus0.busy, 1'b0);
        chk("rst_target", bus0.target, 1'b0);
        chk("rst_timeout", bus0.err_timeout, 1'b0);
        rst_n = 1'b1;
        nop(2);

        // single set: s for exactly PW cycles, done, then idle after gap
        req(1, 0, 0, 0); nop(1);
        chk("set_s_c1", s0, 1'b1); chk("set_r_c1", r0, 1'b0);
        chk("set_busy", bus0.busy, 1'b1); chk("set_target", bus0.target, 1'b1);
        nop(1); chk("set_s_c2", s0, 1'b1);
        nop(1); chk("set_s_c3", s0, 1'b0);
        nop(1); chk("set_done", bus0.done, 1'b1);
        nop(1); chk("set_done_1cyc", bus0.done, 1'b0); chk("set_gap_busy", bus0.busy, 1'b1);
        nop(1); chk("set_idle", bus0.busy, 1'b0); chk("set_tgt_hold", bus0.target, 1'b1);

        // set+clr collision on both priority settings
        nop(1);
        req(1, 1, 0, 0); nop(1);
        chk("conf_p1_s", s0, 1'b1); chk("conf_p1_r", r0, 1'b0);
        chk("conf_p0_s", s1, 1'b0); chk("conf_p0_r", r1, 1'b1);
        chk("conf_p1_flag", bus0.err_conflict, 1'b1);
        chk("conf_p0_flag", bus1.err_conflict, 1'b1);
        nop(1); chk("conf_flag_1cyc", bus0.err_conflict, 1'b0);
        nop(6);

        // set, then clr and tog while busy: tog is the surviving pending entry
        req(1, 0, 0, 0); req(0, 1, 0, 0); req(0, 0, 1, 0);
        nop(1);                               // after E+2
        nop(3);                               // after E+5: tog launched
        chk("lw_r", r0, 1'b1); chk("lw_target", bus0.target, 1'b0);
        chk("lw_busy", bus0.busy, 1'b1);
        nop(3); chk("lw_done", bus0.done, 1'b1);
        nop(6); chk("lw_single_tog", bus0.busy, 1'b0);

        // reset on the second drive cycle
        req(1, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst_s_before", s0, 1'b1);
        bus0.set_req = 0; bus0.tog_req = 1; rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_s", s0, 1'b0); chk("mid_rst_busy", bus0.busy, 1'b0);
        chk("mid_rst_target", bus0.target, 1'b0);
        rst_n = 1'b1; bus0.tog_req = 0;
        nop(3); chk("mid_rst_no_pend", bus0.busy, 1'b0);
        req(1, 0, 0, 0); nop(7);

        // settle timeout with q_fb held low
        force_low = 1'b1;
        req(1, 0, 0, 0); nop(1);
        nop(9); chk("to_not_yet", bus0.err_timeout, 1'b0);
        nop(1); chk("to_set", bus0.err_timeout, 1'b1); chk("to_no_done", bus0.done, 1'b0);
        nop(2);
        req(0, 1, 0, 0); nop(4);
        chk("to_sticky", bus0.err_timeout, 1'b1); chk("to_clr_done", bus0.done, 1'b1);
        req(0, 0, 0, 1); nop(1);
        chk("to_cleared", bus0.err_timeout, 1'b0);
        force_low = 1'b0;
        nop(4);

        // random request stream
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            bus0.set_req = ($urandom_range(0, 7) == 0);
            bus0.clr_req = ($urandom_range(0, 7) == 0);
            bus0.tog_req = ($urandom_range(0, 7) == 0);
            bus0.err_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) force_low = ~force_low;
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1; force_low = 1'b0;
        nop(20);

        n_checks++;
        if (dut_done != m_concl - m_toev) begin
            n_fail++;
            $display("FAIL done_count got=%0d exp=%0d", dut_done, m_concl - m_toev);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
